// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data memory responder: FSM encoding, bus constants,
// wait-state limit and the address range helper.
package data_memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

    typedef enum logic {
        ACCESS_READ  = 1'b0,
        ACCESS_WRITE = 1'b1
    } access_kind_t;

    localparam int          BUS_ADDR_WIDTH    = 32;
    localparam int          BUS_DATA_WIDTH    = 32;
    localparam logic [31:0] READ_DATA_RESET   = 32'h0000_0000;
    localparam logic [31:0] OUT_OF_RANGE_DATA = 32'h0000_0000;
    localparam int          WAIT_STATES_MAX   = 15;
    localparam int          WAIT_COUNT_WIDTH  = 4;

    // Everything captured when a request is accepted in IDLE.
    typedef struct packed {
        access_kind_t               kind;
        logic                       in_range;
        logic [BUS_ADDR_WIDTH-1:0]  address;
        logic [BUS_DATA_WIDTH-1:0]  write_data;
    } dmem_request_t;

    // Addresses below base wrap through the unsigned subtract and land out of range.
    function automatic logic address_in_range(
        input logic [31:0] address,
        input logic [31:0] base,
        input int          word_addr_width
    );
        logic [31:0] offset;
        logic [32:0] limit;
        offset = address - base;
        limit  = 33'd1 << word_addr_width;
        return ({3'b000, offset[31:2]} < limit);
    endfunction

endpackage

// File: rtl/data_memory_responder_dmem_ram.sv
// Single-port synchronous RAM: one 32-bit word per address, write and registered
// read on the same rising edge (read returns the pre-write contents).
module dmem_ram
    import data_memory_responder_pkg::*;
#(
    parameter int WORD_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       write_enable,
    input  logic [WORD_ADDR_WIDTH-1:0] address,
    input  logic [BUS_DATA_WIDTH-1:0]  write_data,
    output logic [BUS_DATA_WIDTH-1:0]  read_data
);

    logic [BUS_DATA_WIDTH-1:0] mem [2**WORD_ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[address] <= write_data;
        end
        read_data <= mem[address];
    end

endmodule

// File: rtl/data_memory_responder.sv
// Level-request data memory slave with a one-cycle completion pulse.
// Optional wait states are built only when DMEM_WAIT_STATES_EN is defined.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS    = 32'h0000_0000,
    parameter int          WORD_ADDR_WIDTH = 12,
    parameter int          WAIT_STATES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_memory_read,
    input  logic        data_memory_write,
    input  logic [31:0] data_address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        data_memory_response,
    output logic        access_error
);

    if (WORD_ADDR_WIDTH < 1 || WORD_ADDR_WIDTH > 30) begin : g_bad_word_addr_width
        $error("data_memory_responder: WORD_ADDR_WIDTH must be 1..30");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait_states
        $error("data_memory_responder: WAIT_STATES must be 0..15");
    end

    dmem_state_t   state;
    dmem_state_t   state_next;
    dmem_request_t req_q;

    logic                       request_seen;
    logic                       accept;
    logic [31:0]                cur_offset;
    logic [31:0]                req_offset;
    logic [WORD_ADDR_WIDTH-1:0] ram_address;
    logic                       ram_write_enable;
    logic [31:0]                ram_read_data;
    logic                       read_done;
    logic [31:0]                read_hold;
    logic                       unused_address_bits;

    assign request_seen = data_memory_read | data_memory_write;
    assign accept       = (state == IDLE) && request_seen;

    assign cur_offset = data_address - BASE_ADDRESS;
    assign req_offset = req_q.address - BASE_ADDRESS;
    assign unused_address_bits = ^{cur_offset, req_offset};

`ifdef DMEM_WAIT_STATES_EN
    localparam logic [WAIT_COUNT_WIDTH-1:0] WAIT_COUNT = WAIT_COUNT_WIDTH'(WAIT_STATES);

    logic [WAIT_COUNT_WIDTH-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= WAIT_COUNT;
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Requests are only looked at in IDLE; the core still holds its request during RESP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (request_seen) begin
`ifdef DMEM_WAIT_STATES_EN
                    state_next = (WAIT_COUNT != '0) ? WAIT : RESP;
`else
                    state_next = RESP;
`endif
                end
            end
            WAIT: begin
`ifdef DMEM_WAIT_STATES_EN
                if (wait_cnt <= WAIT_COUNT_WIDTH'(1)) begin
                    state_next = RESP;
                end
`else
                state_next = IDLE;
`endif
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.kind       <= data_memory_write ? ACCESS_WRITE : ACCESS_READ;
            req_q.in_range   <= address_in_range(data_address, BASE_ADDRESS, WORD_ADDR_WIDTH);
            req_q.address    <= data_address;
            req_q.write_data <= write_data;
        end
    end

    // The RAM reads on the edge that enters RESP; with no wait states that is
    // the accepting edge, so the live bus address is used while in IDLE.
    assign ram_address = (state == IDLE) ? cur_offset[WORD_ADDR_WIDTH+1:2]
                                         : req_offset[WORD_ADDR_WIDTH+1:2];

    assign ram_write_enable = !reset && (state == RESP) &&
                              (req_q.kind == ACCESS_WRITE) && req_q.in_range;

    dmem_ram #(
        .WORD_ADDR_WIDTH(WORD_ADDR_WIDTH)
    ) u_dmem_ram (
        .clk         (clk),
        .write_enable(ram_write_enable),
        .address     (ram_address),
        .write_data  (req_q.write_data),
        .read_data   (ram_read_data)
    );

    assign data_memory_response = (state == RESP);
    assign access_error         = (state == RESP) && !req_q.in_range;
    assign read_done            = (state == RESP) && (req_q.kind == ACCESS_READ);

    always_comb begin
        read_data = read_hold;
        if (read_done) begin
            read_data = req_q.in_range ? ram_read_data : OUT_OF_RANGE_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_hold <= READ_DATA_RESET;
        end else begin
            read_hold <= read_data;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed plus randomized bench for data_memory_responder against a word-array model.
module tb_data_memory_responder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          WAW   = 12;
    localparam int          DEPTH = 1 << WAW;
`ifdef DMEM_WAIT_STATES_EN
    localparam int LAT = 1 + 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        reset;
    logic        data_memory_read;
    logic        data_memory_write;
    logic [31:0] data_address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        data_memory_response;
    logic        access_error;

    int errors;
    int checks;

    logic [31:0] model_mem [int unsigned];
    logic [31:0] exp_q [$];
    logic [31:0] exp_rd;
    logic [31:0] pool [8];

    data_memory_responder #(
        .BASE_ADDRESS   (BASE),
        .WORD_ADDR_WIDTH(WAW),
        .WAIT_STATES    (2)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .data_memory_read    (data_memory_read),
        .data_memory_write   (data_memory_write),
        .data_address        (data_address),
        .write_data          (write_data),
        .read_data           (read_data),
        .data_memory_response(data_memory_response),
        .access_error        (access_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        data_memory_read  = 1'b0;
        data_memory_write = 1'b0;
        data_address      = 32'h0;
        write_data        = 32'h0;
    endtask

    // Starts at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after RESP.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic release_after);
        int          resp_cycle;
        logic [31:0] idx;
        logic        inr;
        idx = (addr - BASE) >> 2;
        inr = (idx < DEPTH);
        if (!wr) exp_rd = inr ? model_mem[idx] : 32'h0;
        exp_q.push_back(exp_rd);
        data_memory_read  = rd;
        data_memory_write = wr;
        data_address      = addr;
        write_data        = wd;
        resp_cycle = -1;
        for (int c = 0; c <= LAT + 4; c++) begin
            @(negedge clk);
            if (data_memory_response === 1'b1) begin
                resp_cycle = c;
                break;
            end
        end
        check("latency", 32'(resp_cycle), 32'(LAT));
        check("read_data", read_data, exp_q.pop_front());
        check("access_error", {31'b0, access_error}, {31'b0, !inr});
        if (wr && inr) model_mem[idx] = wd;
        @(posedge clk);
        #1;
        if (release_after) begin
            drive_idle();
            @(negedge clk);
            check("no_dup_response", {31'b0, data_memory_response}, 32'h0);
            check("hold_read_data", read_data, exp_rd);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic        r;
        logic        w;
        int          kind;
        errors = 0;
        checks = 0;
        exp_rd = 32'h0;
        drive_idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_response", {31'b0, data_memory_response}, 32'h0);
        check("reset_error", {31'b0, access_error}, 32'h0);
        check("reset_read_data", read_data, 32'h0);
        @(posedge clk);
        #1;

        // Write then read back.
        do_access(1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b1);
        do_access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1);

        // Read held through RESP yields one access only.
        do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1);

        // Out-of-range read and dropped write; index 0 must stay intact.
        do_access(1'b1, 1'b0, 32'h0000_4000, 32'h0, 1'b1);
        do_access(1'b0, 1'b1, 32'h0000_4000, 32'h5555_AAAA, 1'b1);
        do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1);

        // Read and write together: write wins, read_data untouched.
        do_access(1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 1'b1);
        do_access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1);

        // Reset during an in-flight write aborts it.
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 1'b1);
        data_memory_write = 1'b1;
        data_address      = 32'h0000_0020;
        write_data        = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        reset = 1'b1;
`ifdef DMEM_WAIT_STATES_EN
        @(negedge clk);
        check("reset_wait_response", {31'b0, data_memory_response}, 32'h0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle();
        exp_rd = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_abort_response", {31'b0, data_memory_response}, 32'h0);
        end
        check("reset_abort_read_data", read_data, 32'h0);
        @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b1);

        // Core-model back-to-back LW/LW/SW then a confirming load.
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
        do_access(1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_0001, 1'b0);
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1);

        // Randomized chained traffic over a prefilled address pool.
        for (int i = 0; i < 8; i++) begin
            pool[i] = BASE + ($urandom_range(DEPTH - 1, 0) << 2);
            do_access(1'b0, 1'b1, pool[i], $urandom, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(9, 0);
            if (kind == 0) a = $urandom_range(32'hFFFF_FFFF, 32'h0000_4000);
            else a = pool[$urandom_range(7, 0)] | 32'($urandom_range(3, 0));
            r = (kind < 6) || (kind == 9);
            w = (kind >= 6);
            do_access(r, w, a, $urandom, ($urandom_range(3, 0) == 0));
        end
        drive_idle();
        @(negedge clk);
        check("final_idle_response", {31'b0, data_memory_response}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
